// File: rtl/m_data_memory.sv
// Word-organised data RAM for the core's dbus load/store port.
// It uses a level request and a single-cycle ack, with a programmable number of wait states.
module m_data_memory #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] dbus_addr_in,
    input  logic        dbus_ld_req_in,
    input  logic        dbus_st_req_in,
    input  logic [31:0] dbus_W_data_in,
    input  logic [3:0]  dbus_byte_en_in,
    output logic [31:0] dbus_rdata_o,
    output logic        dbus_ack_o
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic [3:0]  lat_be;
    logic        lat_st;
    logic [31:0] rdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        req;
    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    logic [3:0]  cur_be;
    logic        cur_st;
    logic [31:0] off;
    logic [29:0] word_off;
    logic        in_range;
    logic [IDX_W-1:0] idx;
    logic        enter_ack;
    logic        off_lo_unused;

    assign req = dbus_ld_req_in | dbus_st_req_in;

    // With zero latency the access completes on the accepting edge, so IDLE uses live inputs
    always_comb begin
        cur_addr = lat_addr;
        cur_data = lat_data;
        cur_be   = lat_be;
        cur_st   = lat_st;
        if (state == IDLE) begin
            cur_addr = dbus_addr_in;
            cur_data = dbus_W_data_in;
            cur_be   = dbus_byte_en_in;
            cur_st   = dbus_st_req_in;
        end
    end

    assign off           = cur_addr - BASE_ADDR;
    assign word_off      = off[31:2];
    assign off_lo_unused = ^off[1:0];
    assign in_range      = (cur_addr >= BASE_ADDR) && ({2'b00, word_off} < 32'(DEPTH_WORDS));
    assign idx           = word_off[IDX_W-1:0];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req) state_nx = (LATENCY > 0) ? WAIT : ACK;
            WAIT: if (cnt == 4'd0) state_nx = ACK;
            ACK:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign enter_ack = (state_nx == ACK) && (state != ACK);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_be   <= '0;
            lat_st   <= 1'b0;
            rdata    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                lat_addr <= dbus_addr_in;
                lat_data <= dbus_W_data_in;
                lat_be   <= dbus_byte_en_in;
                lat_st   <= dbus_st_req_in;
                cnt      <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_ack && !cur_st) begin
                rdata <= in_range ? mem[idx] : '0;
            end
        end
    end

    // Array is never cleared; reset gating keeps an aborted access from writing
    always_ff @(posedge clk_in) begin
        if (rst_in && enter_ack && cur_st && in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cur_be[i]) mem[idx][8*i +: 8] <= cur_data[8*i +: 8];
            end
        end
    end

    assign dbus_rdata_o = rdata;
    assign dbus_ack_o   = (state == ACK);

endmodule
